// File: rtl/forwarding_hazard_unit.sv
// rtl/forwarding_hazard_unit.sv - operand-bypass select and load-use stall controller for a 5-stage pipeline
//
// Purpose:
//   Tracks the destination registers of the instructions in the EX, MEM and WB
//   slots and, for the instruction currently in ID, works out where each source
//   operand should come from once that instruction reaches EX. The selects are
//   registered on the edge that moves the instruction into EX. A load sitting in
//   EX whose result is needed by the ID instruction raises a one-cycle stall.
//
// Ports:
//   i_Clock          clock, rising edge
//   i_Reset          asynchronous active-low reset
//   i_IssueValid     ID holds a valid instruction that wants to enter EX
//   i_IssueRs1/Rs2   source register specifiers of the ID instruction
//   i_IssueUsesRs1/2 the ID instruction actually reads rs1 / rs2
//   i_IssueRd        destination register of the ID instruction
//   i_IssueRegWrite  the ID instruction writes rd
//   i_IssueIsLoad    the ID instruction is a load (result only from WB)
//   i_Flush          squash the ID instruction and the EX slot
//   o_SelRs1/2       operand mux selects for the instruction in EX
//                    00 regfile, 01 MEM ALU result, 10 WB result, 11 retire latch
//   o_Stall          hold IF/ID this cycle; a bubble is inserted into EX

module forwarding_hazard_unit #(
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int ZERO_REG_FORWARD = 0
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_IssueValid,
    input  logic [REG_ADDR_WIDTH-1:0] i_IssueRs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_IssueRs2,
    input  logic                      i_IssueUsesRs1,
    input  logic                      i_IssueUsesRs2,
    input  logic [REG_ADDR_WIDTH-1:0] i_IssueRd,
    input  logic                      i_IssueRegWrite,
    input  logic                      i_IssueIsLoad,
    input  logic                      i_Flush,
    output logic [1:0]                o_SelRs1,
    output logic [1:0]                o_SelRs2,
    output logic                      o_Stall
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    localparam logic [1:0] SEL_RET = 2'b11;

    // Shadow scoreboard. Only the EX slot needs the load flag: a load that has
    // already reached MEM can be bypassed from WB next cycle without stalling.
    logic                      ex_valid_q,  ex_valid_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_q,     ex_rd_d;
    logic                      ex_rw_q,     ex_rw_d;
    logic                      ex_load_q,   ex_load_d;
    logic                      mem_valid_q, mem_valid_d;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_q,    mem_rd_d;
    logic                      mem_rw_q,    mem_rw_d;
    logic                      wb_valid_q,  wb_valid_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q,     wb_rd_d;
    logic                      wb_rw_q,     wb_rw_d;

    logic [1:0] sel_rs1_q, sel_rs1_d;
    logic [1:0] sel_rs2_q, sel_rs2_d;

    logic m1_ex, m1_mem, m1_wb;
    logic m2_ex, m2_mem, m2_wb;
    logic stall;
    logic issue_accept;

    function automatic logic producer_match(
        input logic                      valid,
        input logic                      regwrite,
        input logic [REG_ADDR_WIDTH-1:0] rd,
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic                      uses
    );
        producer_match = valid & regwrite & uses & (rd == rs) &
                         ((ZERO_REG_FORWARD != 0) || (rs != '0));
    endfunction

    // Youngest producer wins: it holds the most recent value of the register.
    function automatic logic [1:0] pick_sel(
        input logic hit_ex,
        input logic hit_mem,
        input logic hit_wb
    );
        if (hit_ex) begin
            pick_sel = SEL_MEM;
        end else if (hit_mem) begin
            pick_sel = SEL_WB;
        end else if (hit_wb) begin
            pick_sel = SEL_RET;
        end else begin
            pick_sel = SEL_RF;
        end
    endfunction

    always_comb begin
        m1_ex  = producer_match(ex_valid_q,  ex_rw_q,  ex_rd_q,  i_IssueRs1, i_IssueUsesRs1);
        m1_mem = producer_match(mem_valid_q, mem_rw_q, mem_rd_q, i_IssueRs1, i_IssueUsesRs1);
        m1_wb  = producer_match(wb_valid_q,  wb_rw_q,  wb_rd_q,  i_IssueRs1, i_IssueUsesRs1);
        m2_ex  = producer_match(ex_valid_q,  ex_rw_q,  ex_rd_q,  i_IssueRs2, i_IssueUsesRs2);
        m2_mem = producer_match(mem_valid_q, mem_rw_q, mem_rd_q, i_IssueRs2, i_IssueUsesRs2);
        m2_wb  = producer_match(wb_valid_q,  wb_rw_q,  wb_rd_q,  i_IssueRs2, i_IssueUsesRs2);

        // producer_match already folds in valid and regwrite; flush overrides.
        stall = i_IssueValid & ~i_Flush & ex_load_q & (m1_ex | m2_ex);

        issue_accept = i_IssueValid & ~stall & ~i_Flush;
    end

    always_comb begin
        ex_valid_d = issue_accept;
        ex_rd_d    = i_IssueRd;
        ex_rw_d    = i_IssueRegWrite;
        ex_load_d  = i_IssueIsLoad;

        // The instruction leaving EX on a flush is on the wrong path; it must
        // never become a forwarding source.
        mem_valid_d = ex_valid_q & ~i_Flush;
        mem_rd_d    = ex_rd_q;
        mem_rw_d    = ex_rw_q;

        wb_valid_d = mem_valid_q;
        wb_rd_d    = mem_rd_q;
        wb_rw_d    = mem_rw_q;

        sel_rs1_d = SEL_RF;
        sel_rs2_d = SEL_RF;
        if (issue_accept) begin
            sel_rs1_d = pick_sel(m1_ex, m1_mem, m1_wb);
            sel_rs2_d = pick_sel(m2_ex, m2_mem, m2_wb);
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_rw_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            sel_rs1_q   <= SEL_RF;
            sel_rs2_q   <= SEL_RF;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_rw_q     <= ex_rw_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_rw_q    <= mem_rw_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            sel_rs1_q   <= sel_rs1_d;
            sel_rs2_q   <= sel_rs2_d;
        end
    end

    assign o_SelRs1 = sel_rs1_q;
    assign o_SelRs2 = sel_rs2_q;
    assign o_Stall  = stall;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb/tb_forwarding_hazard_unit.sv - directed vector bench for forwarding_hazard_unit

module tb_forwarding_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic [4:0] i_rs1, i_rs2, i_rd;
    logic       i_u1, i_u2, i_rw, i_ld, i_flush;
    logic [1:0] sel1, sel2;
    logic       stall;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    forwarding_hazard_unit #(
        .REG_ADDR_WIDTH   (5),
        .ZERO_REG_FORWARD (0)
    ) dut (
        .i_Clock         (clk),
        .i_Reset         (rst_n),
        .i_IssueValid    (i_valid),
        .i_IssueRs1      (i_rs1),
        .i_IssueRs2      (i_rs2),
        .i_IssueUsesRs1  (i_u1),
        .i_IssueUsesRs2  (i_u2),
        .i_IssueRd       (i_rd),
        .i_IssueRegWrite (i_rw),
        .i_IssueIsLoad   (i_ld),
        .i_Flush         (i_flush),
        .o_SelRs1        (sel1),
        .o_SelRs2        (sel2),
        .o_Stall         (stall)
    );

    typedef struct {
        string      nm;
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       flush;
        logic       exp_stall;
        logic [1:0] exp_s1;
        logic [1:0] exp_s2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, bit valid, int rs1, bit u1, int rs2, bit u2,
                                int rd, bit rw, bit ld, bit fl, bit st, int s1, int s2);
        vec_t r;
        r.nm = nm; r.valid = valid;
        r.rs1 = rs1[4:0]; r.u1 = u1; r.rs2 = rs2[4:0]; r.u2 = u2;
        r.rd = rd[4:0]; r.rw = rw; r.ld = ld; r.flush = fl;
        r.exp_stall = st; r.exp_s1 = s1[1:0]; r.exp_s2 = s2[1:0];
        return r;
    endfunction

    function automatic vec_t nop(string nm);
        return mk(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(vec_t x);
        i_valid = x.valid; i_rs1 = x.rs1; i_u1 = x.u1; i_rs2 = x.rs2; i_u2 = x.u2;
        i_rd = x.rd; i_rw = x.rw; i_ld = x.ld; i_flush = x.flush;
    endtask

    task automatic check(string nm, logic [1:0] act, logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    // Called at posedge+1: drive, check the combinational stall, then the
    // selects registered on the following edge.
    task automatic step(vec_t x);
        drive(x);
        #1;
        check({x.nm, ".stall"}, {1'b0, stall}, {1'b0, x.exp_stall});
        @(posedge clk);
        #1;
        check({x.nm, ".sel1"}, sel1, x.exp_s1);
        check({x.nm, ".sel2"}, sel2, x.exp_s2);
    endtask

    initial begin
        //            name         v rs1 u1 rs2 u2 rd rw ld fl st s1 s2
        vecs.push_back(mk("add_x5",  1, 1, 1, 2, 1,  5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sub_x5",  1, 5, 1, 6, 1,  8, 1, 0, 0, 0, 1, 0));
        vecs.push_back(nop("nop2"));
        vecs.push_back(nop("nop3"));
        vecs.push_back(mk("add_x7",  1, 1, 1, 2, 1,  7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop("nop5"));
        vecs.push_back(mk("or_x7",   1, 9, 1, 7, 1, 10, 1, 0, 0, 0, 0, 2));
        vecs.push_back(mk("add_x11", 1, 1, 1, 2, 1, 11, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop("nop8"));
        vecs.push_back(nop("nop9"));
        vecs.push_back(mk("and_x11", 1, 11, 1, 11, 1, 11, 1, 0, 0, 0, 3, 3));
        vecs.push_back(mk("sub_x11", 1, 11, 1, 3, 1, 15, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("add_x12", 1, 1, 1, 2, 1, 12, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop("nop13"));
        vecs.push_back(nop("nop14"));
        vecs.push_back(nop("nop15"));
        vecs.push_back(mk("use_x12", 1, 12, 1, 0, 0, 16, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw_x3",   1, 1, 1, 0, 0,  3, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("lu_stall",1, 3, 1, 2, 1, 20, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk("lu_go",   1, 3, 1, 2, 1, 20, 1, 0, 0, 0, 2, 0));
        vecs.push_back(mk("add_x0",  1, 1, 1, 2, 1,  0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("use_x0",  1, 0, 1, 0, 1, 21, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw_x0",   1, 1, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("lu_x0",   1, 0, 1, 2, 1, 22, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw_x4",   1, 1, 1, 0, 0,  4, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("flush",   1, 4, 1, 2, 1, 23, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("post_fl", 1, 4, 1, 2, 1, 24, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("invalid", 0, 24, 1, 24, 1, 9, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("or_x24",  1, 24, 1, 24, 1, 26, 1, 0, 0, 0, 2, 2));
        vecs.push_back(mk("add_x25", 1, 1, 1, 2, 1, 25, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop("nop30"));
        vecs.push_back(mk("nop_fl",  1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("sub_x25", 1, 3, 1, 25, 1, 27, 1, 0, 0, 0, 0, 3));

        // Reset held while inputs toggle randomly: nothing may be tracked.
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            i_valid = 1'($urandom); i_rs1 = 5'($urandom); i_rs2 = 5'($urandom);
            i_u1 = 1'($urandom); i_u2 = 1'($urandom); i_rd = 5'($urandom);
            i_rw = 1'($urandom); i_ld = 1'($urandom); i_flush = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst.sel1", sel1, 2'b00);
            check("rst.sel2", sel2, 2'b00);
            check("rst.stall", {1'b0, stall}, 2'b00);
        end
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) step(vecs[i]);

        // Asynchronous reset mid-operation drops the registered select and the
        // tracked producers at once.
        step(mk("m_add_x5", 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0));
        step(mk("m_sub_x5", 1, 5, 1, 5, 1, 8, 1, 0, 0, 0, 1, 1));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst.sel1", sel1, 2'b00);
        check("async_rst.sel2", sel2, 2'b00);
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(mk("after_rst_x5", 1, 5, 1, 8, 1, 9, 1, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Operand-bypass controller for the 5-stage pipeline (ID, EX, MEM, WB, retire).
- Keeps its own shadow scoreboard of destination registers for the EX, MEM and WB slots.
- Produces the registered 2-bit selects that drive the two Mux4To1 operand muxes at the EX inputs.
- Raises the load-use stall toward IF/ID.

Parameters:
- REG_ADDR_WIDTH, 5, width of register specifiers.
- ZERO_REG_FORWARD, 0, when 0, register x0 is never a forwarding source or stall cause.

Ports:
- i_Clock  in  1  system clock, rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- i_IssueValid  in  1  ID holds a valid instruction that wants to enter EX this cycle.
- i_IssueRs1  in  REG_ADDR_WIDTH  source register 1 of the ID instruction.
- i_IssueRs2  in  REG_ADDR_WIDTH  source register 2 of the ID instruction.
- i_IssueUsesRs1  in  1  the ID instruction reads rs1.
- i_IssueUsesRs2  in  1  the ID instruction reads rs2.
- i_IssueRd  in  REG_ADDR_WIDTH  destination register of the ID instruction.
- i_IssueRegWrite  in  1  the ID instruction writes rd.
- i_IssueIsLoad  in  1  the ID instruction is a load; its result is available only from WB.
- i_Flush  in  1  squash the ID instruction and the EX slot (branch taken in EX).
- o_SelRs1  out  2  operand-1 mux select for the instruction in EX.
- o_SelRs2  out  2  operand-2 mux select for the instruction in EX.
- o_Stall  out  1  hold IF/ID this cycle; the unit inserts a bubble into EX.

Behaviour:
- Clock and reset: one clock, i_Clock; reset is asynchronous, active-low, on i_Reset.
- Reset state:
  - All three slots (EX, MEM, WB) are invalid.
  - o_SelRs1 = o_SelRs2 = 2'b00.
  - o_Stall = 0.
  - Reset asserted mid-operation discards all tracked producers immediately.
- Select encoding, as seen by the instruction in EX:
  - 00: register-file read.
  - 01: MEM-stage ALU result (producer 1 older).
  - 10: WB-stage result (producer 2 older, ALU or load).
  - 11: retire latch (producer 3 older; covers write-then-read of the register file).
- Each slot holds valid, rd, regwrite and isload.
- Every cycle, WB is discarded, MEM moves to WB and EX moves to MEM.
- EX loading rule:
  - EX loads the ID instruction when i_IssueValid=1, o_Stall=0 and i_Flush=0.
  - Otherwise EX loads a bubble (valid=0).
- Selects:
  - Computed combinationally in ID and registered on the same edge that loads EX, so they are valid during the EX cycle (latency 1).
  - Producer match: slot valid, regwrite=1, rd == rs, the source is used, and rs != 0 unless ZERO_REG_FORWARD=1.
  - Matching against the current slots, youngest first: EX gives 01, MEM gives 10, WB gives 11, no match gives 00.
  - When EX loads a bubble, both registered selects become 00.
- Load-use stall (combinational):
  - o_Stall = i_IssueValid & ~i_Flush & EX.valid & EX.isload & EX.regwrite & (matches rs1 or rs2, with the same x0 rule).
  - The stall lasts exactly one cycle. Next cycle the load is in MEM and its match selects 10.
- A load matched in MEM (not EX) causes no stall; it selects 10.
- Simultaneous flush and stall: i_Flush wins, o_Stall = 0 and EX gets a bubble. MEM and WB are unaffected by flush.
- An instruction with rd == rs1 == rs2 uses the same rule for both operands independently.

Test Plan:
- Reset asserted with random inputs, then released → o_SelRs1/o_SelRs2 = 00, o_Stall = 0; first issue with no producers gives 00/00.
- Issue "add x5" then "sub rs1=x5, rs2=x6" back-to-back → in the sub's EX cycle, o_SelRs1 = 01, o_SelRs2 = 00.
- Issue "add x7", a non-writing instruction, then "or rs2=x7" → o_SelRs2 = 10. With two intervening instructions → 11. With three → 00.
- Issue "lw x3" then "add rs1=x3":
  - o_Stall = 1 for one cycle and a bubble enters EX with selects 00.
  - The next cycle the add issues with o_SelRs1 = 10 and o_Stall = 0.
- Issue "add x0" then "add rs1=x0" with ZERO_REG_FORWARD=0 → select 00. Issue "lw x0" then a use of x0 → no stall.
- Issue "lw x4", then assert i_Flush in the same cycle as a dependent "add rs1=x4" in ID → o_Stall = 0, the EX bubble gives 00/00, and the flushed load never forwards.
